// File: rtl/tx_channel_modulator_if.sv
// Sample-stream bundle for tx_channel_modulator: baseband in, phase increment
// load, upconverted sample out, each direction with its own valid/ready pair.
interface tx_channel_modulator_if #(
    parameter int WIDTH = 16
) ();
    logic signed [WIDTH-1:0] i_inph;
    logic signed [WIDTH-1:0] i_quad;
    logic                    i_valid;
    logic                    o_ready;
    logic [11:0]             i_phase_inc;
    logic                    i_phase_inc_valid;
    logic signed [WIDTH-1:0] o_inph;
    logic signed [WIDTH-1:0] o_quad;
    logic                    o_inph_oflow;
    logic                    o_quad_oflow;
    logic                    o_valid;
    logic                    i_ready;

    modport slave (
        input  i_inph, i_quad, i_valid, i_phase_inc, i_phase_inc_valid, i_ready,
        output o_ready, o_inph, o_quad, o_inph_oflow, o_quad_oflow, o_valid
    );

    modport master (
        output i_inph, i_quad, i_valid, i_phase_inc, i_phase_inc_valid, i_ready,
        input  o_ready, o_inph, o_quad, o_inph_oflow, o_quad_oflow, o_valid
    );
endinterface

// File: rtl/tx_channel_modulator.sv
// Five-stage I/Q upconverter: phase accumulator, quarter-wave cos/sin ROM,
// complex rotation, round and overflow detect. Define TX_CHMOD_SATURATE_EN to clamp overflows.
module tx_channel_modulator #(
    parameter int WIDTH        = 16,
    parameter int NUM_CHANNELS = 4096
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    tx_channel_modulator_if.slave bus
);
    localparam int PW  = 12;
    localparam int AW  = 18;
    localparam int PRW = WIDTH + AW;
    localparam int SW  = WIDTH + 19;
    localparam int QN  = 1025;
    localparam logic [PW-1:0]    PHASE_MASK = PW'(NUM_CHANNELS - 1);
    localparam logic [WIDTH-1:0] MAXV       = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV       = {1'b1, {(WIDTH-1){1'b0}}};
`ifdef TX_CHMOD_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    typedef logic [QN-1:0][AW-1:0] qw_t;

    // First quadrant of round(131071*cos), entries 0..1024 inclusive.
    function automatic qw_t build_qw();
        qw_t t;
        int  k;
        t = '0;
        for (int hi = 0; hi < 33; hi++) begin
            for (int lo = 0; lo < 32; lo++) begin
                k = hi * 32 + lo;
                if (k < QN)
                    t[k] = AW'(int'(131071.0 * $cos(6.283185307179586 * real'(k) / 4096.0)));
            end
        end
        return t;
    endfunction

    localparam qw_t QW = build_qw();

    logic [PW-1:0] acc;
    logic [PW-1:0] inc;
    logic [4:0]    vld;
    logic          en;
    logic          accept;

    logic [PW-1:0]           s1_phase;
    logic signed [WIDTH-1:0] s1_i, s1_q, s2_i, s2_q;
    logic signed [AW-1:0]    s2_cos, s2_sin;
    logic signed [PRW-1:0]   s3_ic, s3_qs, s3_qc, s3_is;
    logic signed [SW-1:0]    s4_si, s4_sq;

    logic signed [WIDTH-1:0] out_i, out_q;
    logic                    out_oi, out_oq;

    // The whole pipeline moves only when the output slot is free or being taken.
    assign en            = ~vld[4] | bus.i_ready;
    assign accept        = bus.i_valid & en;
    assign bus.o_ready   = en;
    assign bus.o_valid   = vld[4];
    assign bus.o_inph    = out_i;
    assign bus.o_quad    = out_q;
    assign bus.o_inph_oflow = out_oi;
    assign bus.o_quad_oflow = out_oq;

    logic [10:0]          ia, ib;
    logic signed [AW-1:0] ta, tb, cos_c, sin_c;

    always_comb begin
        // NOTE: every always_comb output is given a value before any branch so no latch can form.
        ia    = {1'b0, s1_phase[9:0]};
        ib    = 11'd1024 - ia;
        ta    = $signed(QW[ia]);
        tb    = $signed(QW[ib]);
        cos_c = ta;
        sin_c = tb;
        case (s1_phase[11:10])
            2'd1:    begin cos_c = -tb; sin_c =  ta; end
            2'd2:    begin cos_c = -ta; sin_c = -tb; end
            2'd3:    begin cos_c =  tb; sin_c = -ta; end
            default: begin cos_c =  ta; sin_c =  tb; end
        endcase
    end

    logic [WIDTH+1:0] rnd_i, rnd_q;
    logic [WIDTH-1:0] fin_i, fin_q;
    logic             ov_i, ov_q;

    always_comb begin
        rnd_i = s4_si[WIDTH+17:16] + (WIDTH+2)'(1);
        rnd_q = s4_sq[WIDTH+17:16] + (WIDTH+2)'(1);
        ov_i  = ~((s4_si[SW-1] == s4_si[SW-2]) && (s4_si[SW-2] == s4_si[SW-3]));
        ov_q  = ~((s4_sq[SW-1] == s4_sq[SW-2]) && (s4_sq[SW-2] == s4_sq[SW-3]));
        fin_i = rnd_i[WIDTH:1];
        fin_q = rnd_q[WIDTH:1];
        if (SATURATE && ov_i) fin_i = s4_si[SW-1] ? MINV : MAXV;
        if (SATURATE && ov_q) fin_q = s4_sq[SW-1] ? MINV : MAXV;
    end

    // Fraction bits below the rounding point and the carry-out are dropped by design.
    logic unused_bits;
    assign unused_bits = ^{s4_si[15:0], s4_sq[15:0], rnd_i[0], rnd_i[WIDTH+1],
                           rnd_q[0], rnd_q[WIDTH+1]};

    // NOTE: datapath registers carry no reset; only valids, phase state and outputs need one.
    always_ff @(posedge i_clock) begin
        if (en) begin
            s1_phase <= acc;
            s1_i     <= bus.i_inph;
            s1_q     <= bus.i_quad;
            s2_cos   <= cos_c;
            s2_sin   <= sin_c;
            s2_i     <= s1_i;
            s2_q     <= s1_q;
            s3_ic    <= PRW'(s2_i) * PRW'(s2_cos);
            s3_qs    <= PRW'(s2_q) * PRW'(s2_sin);
            s3_qc    <= PRW'(s2_q) * PRW'(s2_cos);
            s3_is    <= PRW'(s2_i) * PRW'(s2_sin);
            s4_si    <= SW'(s3_ic) - SW'(s3_qs);
            s4_sq    <= SW'(s3_qc) + SW'(s3_is);
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            acc    <= '0;
            inc    <= '0;
            vld    <= '0;
            out_i  <= '0;
            out_q  <= '0;
            out_oi <= 1'b0;
            out_oq <= 1'b0;
        end else begin
            // A load in the same cycle as an accept takes effect from the following step.
            if (bus.i_phase_inc_valid) inc <= bus.i_phase_inc;
            if (accept) acc <= (acc + inc) & PHASE_MASK;
            if (en) begin
                vld    <= {vld[3:0], accept};
                out_i  <= fin_i;
                out_q  <= fin_q;
                out_oi <= ov_i;
                out_oq <= ov_q;
            end
        end
    end
endmodule

// File: tb/tb_tx_channel_modulator.sv
// Scoreboard bench for tx_channel_modulator: directed scenarios plus random
// traffic checked against a trigonometric reference model.
module tb_tx_channel_modulator;
    localparam int W = 16;
`ifdef TX_CHMOD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic signed [W-1:0] i;
        logic signed [W-1:0] q;
        logic                oi;
        logic                oq;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tx_channel_modulator_if #(.WIDTH(W)) bus ();

    tx_channel_modulator #(.WIDTH(W), .NUM_CHANNELS(4096)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   m_phase  = 0;
    int   m_inc    = 0;
    int   first_acc_cyc = 0;
    bit   need_lat = 1'b1;
    bit   lat_armed = 1'b0;
    bit   prev_stalled = 1'b0;
    exp_t held;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int i, input int q, input bit oi, input bit oq);
        exp_t e;
        e.i = W'(i); e.q = W'(q); e.oi = oi; e.oq = oq;
        return e;
    endfunction

    function automatic bit ovf(input longint s);
        longint lim;
        lim = longint'(1) << (W + 16);
        return (s >= lim) || (s < -lim);
    endfunction

    function automatic logic signed [W-1:0] rnd(input longint s);
        longint t;
        if (SAT && ovf(s)) return (s < 0) ? W'(-(1 << (W-1))) : W'((1 << (W-1)) - 1);
        t = ((s >>> 16) + 1) >>> 1;
        return W'(t);
    endfunction

    // Rotation of (i,q) by 2*pi*p/4096 using 17-bit-scaled rounded cos/sin.
    function automatic exp_t model(input int p, input logic signed [W-1:0] di,
                                   input logic signed [W-1:0] dq);
        real    th;
        longint c, s, si, sq;
        exp_t   e;
        th = 2.0 * 3.14159265358979323846 * real'(p) / 4096.0;
        c  = longint'(131071.0 * $cos(th));
        s  = longint'(131071.0 * $sin(th));
        si = longint'(di) * c - longint'(dq) * s;
        sq = longint'(dq) * c + longint'(di) * s;
        e.i = rnd(si); e.q = rnd(sq); e.oi = ovf(si); e.oq = ovf(sq);
        return e;
    endfunction

    task automatic drive(input bit v, input logic signed [W-1:0] di, input logic signed [W-1:0] dq,
                         input bit lv, input logic [11:0] li, input bit rdy,
                         input bit use_exp, input exp_t ex);
        @(negedge clk);
        bus.i_valid = v; bus.i_inph = di; bus.i_quad = dq;
        bus.i_phase_inc_valid = lv; bus.i_phase_inc = li; bus.i_ready = rdy;
        #1;
        if (v && bus.o_ready) begin
            sb.push_back(use_exp ? ex : model(m_phase, di, dq));
            if (need_lat) begin first_acc_cyc = cyc; lat_armed = 1'b1; need_lat = 1'b0; end
            m_phase = (m_phase + m_inc) % 4096;
        end
        if (lv) m_inc = int'(li);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.i_valid = 1'b0; bus.i_phase_inc_valid = 1'b0; bus.i_ready = 1'b1;
        #3 rst = 1'b1;
        #1;
        check("rst_o_valid", bus.o_valid, 0);
        check("rst_o_inph", bus.o_inph, 0);
        check("rst_o_quad", bus.o_quad, 0);
        check("rst_oflow", {bus.o_inph_oflow, bus.o_quad_oflow}, 0);
        sb.delete();
        m_phase = 0; m_inc = 0;
        prev_stalled = 1'b0; lat_armed = 1'b0; need_lat = 1'b1;
        @(negedge clk);
        #3 rst = 1'b0;
        #1 check("post_rst_o_ready", bus.o_ready, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && sb.size() != 0; k++) drive(0, 0, 0, 0, 0, 1, 0, '0);
        check("drain_left", sb.size(), 0);
    endtask

    // Monitor: compares each transferred output and checks stall hold behaviour.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (prev_stalled) begin
                    check("hold_valid", bus.o_valid, 1);
                    check("hold_inph", bus.o_inph, held.i);
                    check("hold_quad", bus.o_quad, held.q);
                    check("hold_flags", {bus.o_inph_oflow, bus.o_quad_oflow}, {held.oi, held.oq});
                end
                if (lat_armed && bus.o_valid) begin
                    check("latency", cyc - first_acc_cyc, 5);
                    lat_armed = 1'b0;
                end
                if (bus.o_valid && bus.i_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL unexpected_out: got (%0d,%0d), want no sample", bus.o_inph, bus.o_quad);
                    end else begin
                        e = sb.pop_front();
                        check("out_inph", bus.o_inph, e.i);
                        check("out_quad", bus.o_quad, e.q);
                        check("out_inph_oflow", bus.o_inph_oflow, e.oi);
                        check("out_quad_oflow", bus.o_quad_oflow, e.oq);
                    end
                end
                prev_stalled = bus.o_valid && !bus.i_ready;
                held = mk(int'(bus.o_inph), int'(bus.o_quad), bus.o_inph_oflow, bus.o_quad_oflow);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic signed [W-1:0] di, dq;
        bus.i_valid = 1'b0; bus.i_inph = '0; bus.i_quad = '0;
        bus.i_phase_inc_valid = 1'b0; bus.i_phase_inc = '0; bus.i_ready = 1'b1;
        do_reset();

        // Zero increment: constant phase 0, identity rotation.
        for (int k = 0; k < 8; k++) drive(1, 1000, 0, 0, 0, 1, 1, mk(1000, 0, 0, 0));
        drain();

        // Quarter-turn steps.
        drive(0, 0, 0, 1, 12'd1024, 1, 0, '0);
        drive(1, 1000, 0, 0, 0, 1, 1, mk(1000, 0, 0, 0));
        drive(1, 1000, 0, 0, 0, 1, 1, mk(0, 1000, 0, 0));
        drive(1, 1000, 0, 0, 0, 1, 1, mk(-1000, 0, 0, 0));
        drive(1, 1000, 0, 0, 0, 1, 1, mk(0, -1000, 0, 0));
        drain();

        // 45 degrees with full-scale input overflows Q only.
        do_reset();
        drive(0, 0, 0, 1, 12'd512, 1, 0, '0);
        drive(1, 0, 0, 0, 0, 1, 1, mk(0, 0, 0, 0));
        drive(1, 32767, 32767, 0, 0, 1, 1, mk(0, SAT ? 32767 : -19197, 0, 1));
        drain();

        // Backpressure: fill under stall, then release.
        drive(0, 0, 0, 1, 12'd1000, 1, 0, '0);
        for (int k = 0; k < 10; k++) drive(1, W'($urandom), W'($urandom), 0, 0, 0, 0, '0);
        check("stall_o_ready", bus.o_ready, 0);
        for (int k = 0; k < 10; k++) drive(1, W'($urandom), W'($urandom), 0, 0, 1, 0, '0);
        drain();

        // Increment load coincident with an accept.
        do_reset();
        drive(1, 1000, 0, 1, 12'd1024, 1, 1, mk(1000, 0, 0, 0));
        drive(1, 1000, 0, 0, 0, 1, 1, mk(1000, 0, 0, 0));
        drive(1, 1000, 0, 0, 0, 1, 1, mk(0, 1000, 0, 0));
        drain();

        // Reset in the middle of a busy stream.
        drive(0, 0, 0, 1, 12'd777, 1, 0, '0);
        for (int k = 0; k < 8; k++) drive(1, W'($urandom), W'($urandom), 0, 0, 1, 0, '0);
        do_reset();
        drive(1, 1000, 0, 0, 0, 1, 1, mk(1000, 0, 0, 0));
        drive(1, 1000, 0, 0, 0, 1, 1, mk(1000, 0, 0, 0));
        drain();

        // Random traffic, random backpressure and occasional increment loads.
        for (int k = 0; k < 400; k++) begin
            di = ($urandom % 8 == 0) ? (($urandom % 2 != 0) ? 16'sd32767 : -16'sd32768) : W'($urandom);
            dq = ($urandom % 8 == 0) ? (($urandom % 2 != 0) ? 16'sd32767 : -16'sd32768) : W'($urandom);
            drive($urandom % 4 != 0, di, dq, $urandom % 16 == 0, 12'($urandom),
                  $urandom % 4 != 0, 0, '0);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tx_channel_modulator.md
TX_CHANNEL_MODULATOR -- requirements
Module: tx_channel_modulator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width of I/Q in and out.
REQ-002 SHALL have parameter NUM_CHANNELS, default 4096, phase steps per cycle; phase width fixed at 12 bits.
REQ-003 SHALL have port i_clock  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports i_inph, i_quad  input  WIDTH  signed baseband sample.
REQ-006 SHALL have port i_valid  input  1  upstream sample valid.
REQ-007 SHALL have port o_ready  output  1  upstream may transfer; accept = i_valid & o_ready.
REQ-008 SHALL have port i_phase_inc  input  12  channel phase increment.
REQ-009 SHALL have port i_phase_inc_valid  input  1  load i_phase_inc.
REQ-010 SHALL have ports o_inph, o_quad  output  WIDTH  signed upconverted sample.
REQ-011 SHALL have ports o_inph_oflow, o_quad_oflow  output  1  per-sample overflow flags.
REQ-012 SHALL have port o_valid  output  1  output sample valid.
REQ-013 SHALL have port i_ready  input  1  downstream accepts; transfer = o_valid & i_ready.

Function
REQ-014 SHALL hold a 12-bit increment register and a 12-bit phase accumulator; the first accepted sample after reset uses phase 0.
REQ-015 SHALL advance the accumulator by the increment register, modulo 4096, on each accept only.
REQ-016 SHALL load i_phase_inc when i_phase_inc_valid=1; a simultaneous accept uses the current phase and steps by the old increment, the new increment applies from the next step.
REQ-017 SHALL generate cos/sin from an internal quarter-wave table: 18-bit signed, value round(131071*cos(2*pi*p/4096)), sin likewise, exact 0 at p=1024/3072.
REQ-018 SHALL compute I = i*cos - q*sin and Q = q*cos + i*sin (rotation by +theta), full precision, WIDTH+19-bit signed sums.
REQ-019 SHALL round each sum S as (S[WIDTH+17:16] + 1) >> 1, truncated to WIDTH bits (scale 2^-17, round half up).
REQ-020 SHALL set oflow when S[WIDTH+18], S[WIDTH+17], S[WIDTH+16] are not all equal.
REQ-021 SHALL have latency 5 cycles from accept to o_valid with no stall, throughput one sample per cycle.
REQ-022 SHALL stall the whole pipeline, accumulator included, when o_valid=1 and i_ready=0; o_ready = ~o_valid | i_ready.
REQ-023 SHALL hold o_inph, o_quad, flags and o_valid stable while stalled.
REQ-024 SHALL propagate bubbles: stages without valid data produce o_valid=0; data of invalid stages is don't-care.

Reset
REQ-025 SHALL on i_reset asynchronously clear o_valid, all stage valids, accumulator and increment register to 0.
REQ-026 SHALL reset o_inph, o_quad, o_inph_oflow, o_quad_oflow to 0.
REQ-027 SHALL discard in-flight samples on reset mid-operation; o_ready=1 in the first cycle after release.

Configuration
REQ-028 SHALL, with TX_CHMOD_SATURATE_EN defined, replace an overflowing output by +2^(WIDTH-1)-1 (S positive) or -2^(WIDTH-1) (S negative), flag still set.
REQ-029 SHALL, without TX_CHMOD_SATURATE_EN, output the wrapped WIDTH-bit rounded value with flag set.

Verification
REQ-030 SHALL test phase_inc=0, input (1000,0) continuous -> output (1000,0) every sample, flags 0, first o_valid 5 cycles after first accept.
REQ-031 SHALL test phase_inc=1024, input (1000,0) x4 -> (1000,0), (0,1000), (-1000,0), (0,-1000).
REQ-032 SHALL test phase_inc=512, one sample at step 1 with input (32767,32767) -> I=0, o_quad_oflow=1, o_quad=32767 with macro, -19197 without.
REQ-033 SHALL test i_ready=0 for 10 cycles with i_valid=1 -> o_ready=0 once pipeline full, outputs held, no sample lost or duplicated, phase sequence continuous after release.
REQ-034 SHALL test i_phase_inc_valid coincident with accept (0 -> 1024) -> that sample at phase 0, next at 0, then 1024.
REQ-035 SHALL test i_reset mid-stream -> o_valid=0 asynchronously, next accepted sample at phase 0 with increment 0.
